grid_cursor_select: RTL and testbench
=====================================

Name: grid_cursor_select

Overview:
- Parameterised cursor/selection engine for one pick step of the colour-matching game on a COLS x ROWS grid of squares.
- When the game step bus equals STEP_ID, it places the cursor on the lowest-index free square and moves it with edge-qualified up/down/left/right presses. It never parks on an occupied square.
- On a select press it latches the pick and pulses done. The game controller then advances the step and adds the pick to the occupied mask.

Parameters:
- COLS, 4, squares per row.
- ROWS, 2, number of rows; N = COLS*ROWS squares.
- IDXW, 3, square index width; must satisfy 2**IDXW >= N.
- STEPW, 4, width of step bus.
- STEP_ID, 7, step value on which this instance is active.

Ports:
- clk25MHz  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step  in  STEPW  current game step.
- up  in  1  level button, synchronous to clk25MHz.
- down  in  1  level button.
- right  in  1  level button.
- left  in  1  level button.
- sel  in  1  level confirm button.
- used_mask  in  N  bit i=1 means square i is already taken.
- cursor  out  IDXW  current highlighted square.
- active  out  1  high while the engine owns the cursor (states READY/SKIP).
- none_free  out  1  high when used_mask is all ones during the step.
- done  out  1  one-cycle pulse when a pick is confirmed.
- chosen  out  IDXW  last confirmed square, held until the next confirm.

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE, cursor=0, chosen=0, active=0, done=0, none_free=0, armed=0, dir=0.
- States: IDLE, INIT, READY, SKIP, DONE.
- IDLE -> INIT when step==STEP_ID. All outputs except done are held.
- INIT (1 cycle): a priority encoder over ~used_mask sets cursor to the lowest free index. If there is none, set none_free=1, keep cursor, stay in INIT. Otherwise go to READY with armed=0.
- Press discipline (armed flag):
  - A move or select is accepted only when armed=1.
  - armed is set in any READY cycle with all five buttons low.
  - armed is cleared when a press is accepted.
  - Result: exactly one action per physical press, however long it is held.
- READY, armed=1, priority up > down > right > left > sel. Moves use modulo-N linear wrap:
  - right: c+1 mod N.
  - left: c-1 mod N.
  - up: c-COLS mod N.
  - down: c+COLS mod N.
- Moves: the computed target is written to cursor the same cycle.
  - If used_mask[target]=1, go to SKIP with dir latched.
  - Otherwise stay in READY.
- SKIP: each cycle apply the latched dir again (one step per cycle) until cursor lands on a free square, then return to READY.
  - All buttons are ignored during SKIP.
  - N steps without finding a free square: set none_free, go to INIT.
- sel accepted in READY:
  - If used_mask[cursor]=0: chosen<=cursor, done=1 for exactly one cycle, go to DONE.
  - If used_mask[cursor]=1 (mask changed under the cursor): no pick, go to INIT to re-place.
- DONE: active=0, cursor held. Return to IDLE when step!=STEP_ID. Remaining in STEP_ID does not re-arm.
- step leaves STEP_ID in INIT/READY/SKIP: go to IDLE next cycle. No done pulse; cursor and chosen are held.
- used_mask change while in READY with cursor now occupied: stay in READY. The next accepted move or sel resolves it as above.
- Arithmetic is done at IDXW+1 bits before the mod-N reduction, so non-power-of-two N wraps correctly (e.g. COLS=3, ROWS=3: left from 0 gives 8).
- Latency:
  - Step entry to active=1: 2 cycles.
  - Accepted press to cursor update: 1 cycle, plus 1 cycle per skipped square.

Test Plan:
- N=8, used_mask=8'b0000_0111, step=7 -> after 2 cycles cursor=3, active=1.
- Same setup, right held 20 cycles then released, then right again -> cursor=4 then 5. Exactly one move per press.
- used_mask=8'b0001_0001, cursor=1, up -> target 5 is free, cursor=5. Then down -> target 1 (5+4 mod 8) is free, cursor=1. Then left -> 0 is used, SKIP continues to 7, cursor=7.
- cursor=6, sel pulse -> done high 1 cycle, chosen=6, state DONE. Further presses have no effect until step!=7.
- used_mask=8'hFF at step entry -> none_free=1, active=0, cursor unchanged, done never asserted.
- Assert rst mid-SKIP -> all outputs 0 immediately (asynchronously). Release with step=7 -> re-INIT to the lowest free square.

Source files
------------

// File: rtl/grid_cursor_select.sv
// grid_cursor_select: cursor placement and pick engine for one step of the
// colour-matching game. While the step bus matches STEP_ID it parks the cursor
// on free squares only, moves it once per button press with modulo-N wrap, and
// latches the confirmed square into chosen with a one-cycle done pulse.
module grid_cursor_select #(
  parameter int COLS    = 4,
  parameter int ROWS    = 2,
  parameter int IDXW    = 3,
  parameter int STEPW   = 4,
  parameter int STEP_ID = 7
) (
  input  logic                   clk25MHz,
  input  logic                   rst,
  input  logic [STEPW-1:0]       step,
  input  logic                   up,
  input  logic                   down,
  input  logic                   right,
  input  logic                   left,
  input  logic                   sel,
  input  logic [COLS*ROWS-1:0]   used_mask,
  output logic [IDXW-1:0]        cursor,
  output logic                   active,
  output logic                   none_free,
  output logic                   done,
  output logic [IDXW-1:0]        chosen
);

  localparam int N = COLS * ROWS;

  // Wrap arithmetic is carried one bit wider than the index so that
  // c + N - k never overflows before the single conditional subtract.
  localparam logic [IDXW:0] LP_N    = (IDXW+1)'(N);
  localparam logic [IDXW:0] LP_COLS = (IDXW+1)'(COLS);
  localparam logic [IDXW:0] LP_ONE  = (IDXW+1)'(1);
  localparam logic [IDXW-1:0] LP_LAST_SKIP = IDXW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READY,
    S_SKIP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    D_UP,
    D_DOWN,
    D_RIGHT,
    D_LEFT
  } dir_t;

  state_t          r_state;
  dir_t            r_dir;
  logic            r_armed;
  logic [IDXW-1:0] r_skip_cnt;
  logic [IDXW-1:0] r_cursor;
  logic [IDXW-1:0] r_chosen;
  logic            r_active;
  logic            r_none_free;
  logic            r_done;

  logic            w_in_step;
  logic            w_any_btn;
  logic            w_any_move;
  dir_t            w_btn_dir;
  dir_t            w_move_dir;
  logic [IDXW:0]   w_cur_ext;
  logic [IDXW:0]   w_sum;
  logic [IDXW:0]   w_wrapped;
  logic [IDXW-1:0] w_target;
  logic            w_target_used;
  logic            w_cursor_used;
  logic [IDXW-1:0] w_first_free;
  logic            w_any_free;
  logic            w_last_skip;

  assign w_in_step     = (step == STEPW'(STEP_ID));
  assign w_any_move    = up | down | right | left;
  assign w_any_btn     = w_any_move | sel;
  assign w_any_free    = ~(&used_mask);
  assign w_last_skip   = (r_skip_cnt == LP_LAST_SKIP);
  assign w_target_used = used_mask[w_target];
  assign w_cursor_used = used_mask[r_cursor];

  // Button priority for moves: up > down > right > left.
  always_comb begin
    w_btn_dir = D_LEFT;
    if (up)         w_btn_dir = D_UP;
    else if (down)  w_btn_dir = D_DOWN;
    else if (right) w_btn_dir = D_RIGHT;
  end

  // Next-square computation: live buttons in READY, latched direction in SKIP.
  always_comb begin
    w_move_dir = (r_state == S_SKIP) ? r_dir : w_btn_dir;
    w_cur_ext  = {1'b0, r_cursor};
    w_sum      = w_cur_ext;
    case (w_move_dir)
      D_UP:    w_sum = w_cur_ext + LP_N - LP_COLS;
      D_DOWN:  w_sum = w_cur_ext + LP_COLS;
      D_RIGHT: w_sum = w_cur_ext + LP_ONE;
      D_LEFT:  w_sum = w_cur_ext + LP_N - LP_ONE;
      default: w_sum = w_cur_ext;
    endcase
    w_wrapped = (w_sum >= LP_N) ? (w_sum - LP_N) : w_sum;
    w_target  = w_wrapped[IDXW-1:0];
  end

  // Lowest-index free square (priority encoder over ~used_mask).
  always_comb begin
    w_first_free = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (!used_mask[i-1]) w_first_free = IDXW'(i - 1);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= D_UP;
      r_armed     <= 1'b0;
      r_skip_cnt  <= '0;
      r_cursor    <= '0;
      r_chosen    <= '0;
      r_active    <= 1'b0;
      r_none_free <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_in_step) r_state <= S_INIT;
        end

        S_INIT: begin
          if (!w_in_step) begin
            r_state <= S_IDLE;
          end else if (!w_any_free) begin
            r_none_free <= 1'b1;
          end else begin
            r_cursor    <= w_first_free;
            r_none_free <= 1'b0;
            r_armed     <= 1'b0;
            r_active    <= 1'b1;
            r_state     <= S_READY;
          end
        end

        S_READY: begin
          if (!w_in_step) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else if (!w_any_btn) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            if (w_any_move) begin
              r_cursor <= w_target;
              if (w_target_used) begin
                r_dir      <= w_btn_dir;
                r_skip_cnt <= '0;
                r_state    <= S_SKIP;
              end
            end else begin
              r_active <= 1'b0;
              if (!w_cursor_used) begin
                r_chosen <= r_cursor;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                // Mask changed under the cursor: re-place instead of picking.
                r_state <= S_INIT;
              end
            end
          end
        end

        S_SKIP: begin
          if (!w_in_step) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cursor <= w_target;
            if (!w_target_used) begin
              r_state <= S_READY;
            end else if (w_last_skip) begin
              // N steps in SKIP without a free square: give up and re-place.
              r_none_free <= 1'b1;
              r_active    <= 1'b0;
              r_state     <= S_INIT;
            end else begin
              r_skip_cnt <= r_skip_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (!w_in_step) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cursor    = r_cursor;
  assign chosen    = r_chosen;
  assign active    = r_active;
  assign none_free = r_none_free;
  assign done      = r_done;

endmodule

// File: tb/tb_grid_cursor_select.sv
// Bench for grid_cursor_select (COLS=4, ROWS=2): directed button/mask vectors,
// a cycle-level behavioural model compared on every falling edge, and
// hand-computed literal checks at the key points of each scenario.
module tb_grid_cursor_select;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int N    = COLS * ROWS;
  localparam int SID  = 7;

  localparam int MD_IDLE  = 0;
  localparam int MD_INIT  = 1;
  localparam int MD_READY = 2;
  localparam int MD_SKIP  = 3;
  localparam int MD_DONE  = 4;

  logic         clk25MHz = 1'b0;
  logic         rst      = 1'b1;
  logic [3:0]   step     = '0;
  logic         up = 1'b0, down = 1'b0, right = 1'b0, left = 1'b0, sel = 1'b0;
  logic [N-1:0] used_mask = '0;
  logic [2:0]   cursor;
  logic         active;
  logic         none_free;
  logic         done;
  logic [2:0]   chosen;

  int n_tests = 0;
  int n_fail  = 0;

  grid_cursor_select #(
    .COLS(COLS),
    .ROWS(ROWS),
    .IDXW(3),
    .STEPW(4),
    .STEP_ID(SID)
  ) dut (
    .clk25MHz (clk25MHz),
    .rst      (rst),
    .step     (step),
    .up       (up),
    .down     (down),
    .right    (right),
    .left     (left),
    .sel      (sel),
    .used_mask(used_mask),
    .cursor   (cursor),
    .active   (active),
    .none_free(none_free),
    .done     (done),
    .chosen   (chosen)
  );

  always #20 clk25MHz = ~clk25MHz;

  // Behavioural model state.
  int m_mode   = MD_IDLE;
  int m_cur    = 0;
  int m_chosen = 0;
  int m_act    = 0;
  int m_nf     = 0;
  int m_done   = 0;
  int m_armed  = 0;
  int m_delta  = 0;
  int m_cnt    = 0;

  // Model: one pick-step rule application per rising edge.
  always @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      m_mode = MD_IDLE; m_cur = 0; m_chosen = 0; m_act = 0;
      m_nf = 0; m_done = 0; m_armed = 0; m_delta = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_mode != MD_IDLE && m_mode != MD_DONE && step != SID) begin
        m_mode = MD_IDLE;
        m_act  = 0;
      end else begin
        case (m_mode)
          MD_IDLE: if (step == SID) m_mode = MD_INIT;
          MD_INIT: begin
            int lo;
            lo = -1;
            for (int i = N - 1; i >= 0; i--) if (!used_mask[i]) lo = i;
            if (lo < 0) m_nf = 1;
            else begin
              m_cur = lo; m_nf = 0; m_armed = 0; m_act = 1; m_mode = MD_READY;
            end
          end
          MD_READY: begin
            if (!(up || down || right || left || sel)) m_armed = 1;
            else if (m_armed) begin
              m_armed = 0;
              if (up || down || right || left) begin
                if (up)         m_delta = N - COLS;
                else if (down)  m_delta = COLS;
                else if (right) m_delta = 1;
                else            m_delta = N - 1;
                m_cur = (m_cur + m_delta) % N;
                if (used_mask[m_cur]) begin m_mode = MD_SKIP; m_cnt = 0; end
              end else begin
                m_act = 0;
                if (!used_mask[m_cur]) begin
                  m_chosen = m_cur; m_done = 1; m_mode = MD_DONE;
                end else m_mode = MD_INIT;
              end
            end
          end
          MD_SKIP: begin
            m_cur = (m_cur + m_delta) % N;
            if (!used_mask[m_cur]) m_mode = MD_READY;
            else begin
              m_cnt++;
              if (m_cnt == N) begin m_nf = 1; m_act = 0; m_mode = MD_INIT; end
            end
          end
          MD_DONE: if (step != SID) m_mode = MD_IDLE;
          default: m_mode = MD_IDLE;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk25MHz) begin
    chk("model_cursor",    int'(cursor),    m_cur);
    chk("model_active",    int'(active),    m_act);
    chk("model_none_free", int'(none_free), m_nf);
    chk("model_done",      int'(done),      m_done);
    chk("model_chosen",    int'(chosen),    m_chosen);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk25MHz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(2);
    chk("reset_cursor", int'(cursor), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_done",   int'(done),   0);
    rst = 1'b0;
    cycles(1);

    // Entry: lowest free square with 0..2 taken is 3, active after 2 cycles.
    used_mask = 8'b0000_0111; step = 4'd7;
    cycles(1);
    chk("entry_active_1cyc", int'(active), 0);
    cycles(1);
    chk("entry_cursor", int'(cursor), 3);
    chk("entry_active", int'(active), 1);

    // One move per press however long it is held.
    cycles(1);
    right = 1'b1; cycles(1);
    chk("right_first", int'(cursor), 4);
    cycles(19);
    chk("right_held", int'(cursor), 4);
    right = 1'b0; cycles(1);
    right = 1'b1; cycles(1);
    chk("right_second", int'(cursor), 5);
    right = 1'b0;

    // Vertical wrap and skip over an occupied square.
    step = 4'd0; cycles(1);
    used_mask = 8'b0001_0001; step = 4'd7; cycles(2);
    chk("reentry_cursor", int'(cursor), 1);
    cycles(1);
    up = 1'b1; cycles(1);
    chk("up_cursor", int'(cursor), 5);
    up = 1'b0; cycles(1);
    down = 1'b1; cycles(1);
    chk("down_cursor", int'(cursor), 1);
    down = 1'b0; cycles(1);
    left = 1'b1; cycles(1);
    chk("left_onto_used", int'(cursor), 0);
    cycles(1);
    chk("left_skip_wrap", int'(cursor), 7);
    left = 1'b0; cycles(1);
    left = 1'b1; cycles(1);
    chk("left_to_6", int'(cursor), 6);
    left = 1'b0; cycles(1);

    // Select: single done pulse, pick latched, further presses ignored.
    sel = 1'b1; cycles(1);
    chk("sel_done", int'(done), 1);
    chk("sel_chosen", int'(chosen), 6);
    cycles(1);
    chk("sel_done_pulse", int'(done), 0);
    sel = 1'b0; cycles(1);
    right = 1'b1; cycles(2);
    chk("done_hold_cursor", int'(cursor), 6);
    chk("done_hold_active", int'(active), 0);
    right = 1'b0;

    // Full mask at entry.
    step = 4'd0; cycles(1);
    used_mask = 8'hFF; step = 4'd7; cycles(2);
    chk("full_none_free", int'(none_free), 1);
    chk("full_active", int'(active), 0);
    chk("full_cursor", int'(cursor), 6);
    cycles(3);
    chk("full_no_done", int'(done), 0);

    // Mask fills while in READY: SKIP exhausts after N steps.
    used_mask = 8'h01; cycles(1);
    chk("refill_cursor", int'(cursor), 1);
    cycles(1);
    used_mask = 8'hFF; right = 1'b1; cycles(1);
    right = 1'b0;
    cycles(8);
    chk("exhaust_none_free", int'(none_free), 1);
    chk("exhaust_cursor", int'(cursor), 2);
    used_mask = 8'h7F; cycles(1);
    chk("recover_cursor", int'(cursor), 7);
    chk("recover_none_free", int'(none_free), 0);

    // Select on a square that became occupied: re-place, no pick.
    cycles(1);
    used_mask = 8'hBF; sel = 1'b1; cycles(1);
    chk("stale_sel_done", int'(done), 0);
    sel = 1'b0; cycles(1);
    chk("stale_sel_replace", int'(cursor), 6);

    // Asynchronous reset in the middle of a skip.
    step = 4'd0; cycles(1);
    used_mask = 8'b0011_1100; step = 4'd7; cycles(2);
    chk("skip_entry_cursor", int'(cursor), 0);
    cycles(1);
    right = 1'b1; cycles(1);
    right = 1'b0; cycles(1);
    right = 1'b1; cycles(1);
    right = 1'b0; cycles(1);
    chk("mid_skip_cursor", int'(cursor), 3);
    #5 rst = 1'b1;
    #1;
    chk("async_rst_cursor", int'(cursor), 0);
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_chosen", int'(chosen), 0);
    chk("async_rst_none_free", int'(none_free), 0);
    @(negedge clk25MHz);
    rst = 1'b0;
    cycles(2);
    chk("post_rst_cursor", int'(cursor), 0);
    chk("post_rst_active", int'(active), 1);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
